result_buffer: RTL

Collects the right-shifted products emitted by the multiplier datapath, one per `write_en` pulse from the controller, into a DEPTH-entry store. On the controller's `write_file` pulse it drains all stored results in arrival order over a valid/ready stream to the file-writer/testbench sink. It sits directly downstream of the datapath shift register and the main controller.

---
 rtl/result_buffer_pkg.sv | 10 +
 rtl/result_buffer_mem.sv | 18 +
 rtl/result_buffer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/result_buffer_pkg.sv
// result_buffer_pkg: shared state encoding and default sizes for the result buffer.
package result_buffer_pkg;
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    DRAIN  = 2'd1,
    FINISH = 2'd2
  } state_e;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF = 16;
endpackage

// File: rtl/result_buffer_mem.sv
// result_mem: DEPTH x DATA_W register file, synchronous write, combinational read.
module result_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_W-1:0]        rd_data
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem_q[wr_addr] <= wr_data;
  end
  assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/result_buffer.sv
// result_buffer: captures datapath results and drains them in order over a valid/ready stream.
module result_buffer
  import result_buffer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   write_en,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   write_file,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow,
  output logic                   drain_done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_addr;
  logic [CW-1:0]     count_q, count_d, rd_nxt;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic              full_q, full_d, overflow_q, overflow_d, drain_done_q, drain_done_d;
  logic [DATA_W-1:0] out_data_q, out_data_d, rd_data;
  logic              we;
  assign rd_nxt  = {1'b0, rd_ptr_q} + CW'(1);
  assign rd_addr = (state_q == FILL) ? '0 : rd_nxt[AW-1:0];
  assign we      = (state_q == FILL) && write_en && !full_q;
  result_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk    (clk),
    .we     (we),
    .wr_addr(wr_ptr_q),
    .wr_data(data_in),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    overflow_d   = overflow_q | (write_en & ((state_q != FILL) | full_q));
    drain_done_d = 1'b0;
    case (state_q)
      FILL: begin
        if (we) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          count_d  = count_q + CW'(1);
        end
        if (write_file) begin
          rd_ptr_d     = '0;
          state_d      = (count_d != '0) ? DRAIN : FINISH;
          drain_done_d = (count_d == '0);
          out_valid_d  = (count_d != '0);
          // entry 0 may be the one being captured this very cycle
          out_data_d   = (we && wr_ptr_q == '0) ? data_in : rd_data;
          out_last_d   = (count_d == CW'(1));
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            state_d      = FINISH;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            drain_done_d = 1'b1;
          end else begin
            rd_ptr_d   = rd_nxt[AW-1:0];
            out_data_d = rd_data;
            out_last_d = (rd_nxt == count_q - CW'(1));
          end
        end
      end
      FINISH: begin
        state_d  = FILL;
        count_d  = '0;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end
      default: state_d = FILL;
    endcase
    full_d = (count_d == CW'(DEPTH));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      drain_done_q <= drain_done_d;
    end
  end
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign count      = count_q;
  assign full       = full_q;
  assign overflow   = overflow_q;
  assign drain_done = drain_done_q;
endmodule
